fetch_mul_arbiter: RTL
======================

Name: fetch_mul_arbiter

Overview:
- Shares one 16x16->20 unsigned multiplier between NUM_REQ requesters inside the fetch-instruction generator, e.g. for DRAM offset and stride products.
- Arbitration is round-robin with valid/ready handshakes on both request and response sides.
- The product is registered, so each request takes exactly one cycle from accept to response.
- The multiplier is combinational; this block owns sequencing, arbitration and result hold.

Parameters:
- NUM_REQ, 2, number of requesters (range 2..8).
- A_W, 16, operand A width.
- B_W, 16, operand B width.
- P_W, 20, product width. The product is truncated to P_W bits.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high.
- req_a  in  NUM_REQ*A_W  flattened operand A; requester i occupies bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  flattened operand B, same packing.
- rsp_valid  out  NUM_REQ  result valid, asserted only toward the owning requester.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_p  out  P_W  shared result bus, equal to (a*b) mod 2^P_W.
- rsp_ovf  out  1  high when the full product exceeds 2^P_W-1.
- op_count  out  32  number of accepted requests; wraps modulo 2^32.

Behaviour:
- Reset, asynchronous with ap_rst high:
  - Clears rsp_valid, rsp_p, rsp_ovf, the owner register and op_count to 0.
  - Sets the round-robin pointer last to NUM_REQ-1, so requester 0 wins first.
  - Any held result is discarded.
  - req_ready is 0 while ap_rst is high.
- Output register is free when no result is held, or when the held result is accepted this cycle (rsp_valid[owner] && rsp_ready[owner]).
- Grant (combinational):
  - Only when the output register is free.
  - Search req_valid starting at index last+1 modulo NUM_REQ; the first set bit wins.
  - req_ready is high only for the winner.
  - If no request is valid, req_ready is all 0.
- Fire on req_valid[g] && req_ready[g]. On the next edge:
  - rsp_p <= product[P_W-1:0] and rsp_ovf <= |product[A_W+B_W-1:P_W].
  - owner <= g, rsp_valid <= one-hot(g), last <= g, op_count <= op_count+1.
- Latency: exactly 1 cycle from fire to rsp_valid.
- Throughput: 1 result/cycle when rsp_ready is held high.
- Hold: while rsp_valid[owner] is high and rsp_ready[owner] is low:
  - rsp_p, rsp_ovf and owner stay stable.
  - No grant is issued.
- Simultaneous drain and fire in one cycle: the new result replaces the old one on the same edge with no bubble. The new owner may equal the old owner.
- If neither a drain nor a fire occurs, rsp_valid clears to 0. rsp_p and rsp_ovf keep their last value (don't-care).
- rsp_ready bits of non-owners are ignored.
- Requester rules:
  - Operands must stay stable while req_valid is high and req_ready is low.
  - A requester may drop req_valid before it is granted; this is legal and the block ignores the dropped request.
- Fairness: with all requesters continuously valid and rsp_ready held high, grants rotate 0,1,...,NUM_REQ-1,0,...
- No combinational path from rsp_ready to rsp_valid. req_ready depends combinationally on req_valid, rsp_ready and state.

Test Plan:
- Single request: after reset, req0 with a=3, b=5 -> req_ready[0] high in the same cycle; next cycle rsp_valid=01, rsp_p=15, rsp_ovf=0, op_count=1.
- Truncation: a=0xFFFF, b=0xFFFF -> rsp_p=0xE0001, rsp_ovf=1. a=0x0400, b=0x0100 (product 0x40000) -> rsp_p=0x40000, rsp_ovf=0.
- Round-robin: both requesters valid continuously with rsp_ready=11 for 6 cycles -> grant order 0,1,0,1,0,1; rsp_valid alternates 01,10 back-to-back; op_count=6.
- Backpressure: hold rsp_ready[1]=0 for 4 cycles after req1 fires (a=7, b=9) -> rsp_p=63 stable, req_ready=00 throughout. Raising rsp_ready[1] grants the pending req0 in that same cycle.
- Reset mid-hold: assert ap_rst while a result is held -> rsp_valid=00 and op_count=0 immediately (asynchronous). After release, req0 wins first.
- Counter wrap: force op_count to 0xFFFFFFFF via a bench-driven hierarchical force/deposit on the counter register, then one fire -> op_count=0.

Source files
------------

// File: rtl/fetch_mul_arbiter_if.sv
// Request/response bundle for the shared fetch multiplier: per-requester
// valid/ready pairs, flattened operands, shared product bus and op counter.
interface fetch_mul_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int A_W     = 16,
    parameter int B_W     = 16,
    parameter int P_W     = 20
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [P_W-1:0]         rsp_p;
    logic                   rsp_ovf;
    logic [31:0]            op_count;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_ovf, op_count
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_ovf, op_count
    );
endinterface

// File: rtl/fetch_mul_arbiter.sv
// Round-robin arbiter sharing one combinational unsigned multiplier between
// NUM_REQ requesters; the truncated product is registered and held until drained.
module fetch_mul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int A_W     = 16,
    parameter int B_W     = 16,
    parameter int P_W     = 20
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    fetch_mul_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int F_W   = A_W + B_W;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [P_W-1:0]     r_rsp_p;
    logic               r_rsp_ovf;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [31:0]        r_op_count;

    logic               w_held;
    logic               w_drain;
    logic               w_free;
    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_fire;
    logic [A_W-1:0]     w_a;
    logic [B_W-1:0]     w_b;
    logic [F_W-1:0]     w_prod;

    // rsp_valid is only ever one-hot at the owner, so any set bit means held.
    assign w_held  = |r_rsp_valid;
    assign w_drain = r_rsp_valid[r_owner] & bus.rsp_ready[r_owner];
    assign w_free  = !w_held || w_drain;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] v_cand;
            v_cand = IDX_W'((32'(r_last) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[v_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = v_cand;
            end
        end
    end

    assign w_req_ready = (!ap_rst && w_free && w_found) ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_fire      = |(bus.req_valid & w_req_ready);

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_a = bus.req_a[i*A_W +: A_W];
                w_b = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    assign w_prod = {{B_W{1'b0}}, w_a} * {{A_W{1'b0}}, w_b};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rsp_valid <= '0;
            r_rsp_p     <= '0;
            r_rsp_ovf   <= 1'b0;
            r_owner     <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_op_count  <= '0;
        end else if (w_fire) begin
            r_rsp_p     <= w_prod[P_W-1:0];
            r_rsp_ovf   <= |w_prod[F_W-1:P_W];
            r_owner     <= w_gnt_idx;
            r_rsp_valid <= NUM_REQ'(1) << w_gnt_idx;
            r_last      <= w_gnt_idx;
            r_op_count  <= r_op_count + 32'd1;
        end else if (!(w_held && !w_drain)) begin
            r_rsp_valid <= '0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.op_count  = r_op_count;
endmodule
